// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } if_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
    logic            misaligned;
  } if_id_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between fetch and decode; flush and idle cycles both leave a NOP bubble.
module if_id_reg
  import rv32_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  logic   stall_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q, q_d;

  // Flush beats stall beats load; an unstalled cycle with nothing to load drains to a bubble.
  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d.valid = 1'b0;
      q_d.inst  = NOP;
    end else if (stall_i) begin
      q_d = q_q;
    end else if (load_i) begin
      q_d = d_i;
    end else begin
      q_d.valid = 1'b0;
      q_d.inst  = NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= {1'b0, 32'h0000_0000, 32'h0000_0004, NOP, 1'b0};
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, stall hold buffer and
// redirect handling (DRAIN keeps the old address until the in-flight word is discarded).
module if_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic [XLEN-1:0] id_inst,
  output logic            id_misaligned
);

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic            mis_q, mis_d, tgt_mis_q, tgt_mis_d;
  if_id_t          buf_q, buf_d;
  if_id_t          fetched_s, id_d_s, id_q_s;
  logic            id_load_s;
  logic [XLEN-1:0] redir_pc_s;
  logic            redir_mis_s;

  assign redir_pc_s  = {redirect_pc[XLEN-1:2], 2'b00};
  assign redir_mis_s = |redirect_pc[1:0];
  assign fetched_s   = {1'b1, pc_q, pc_next(pc_q), imem_rdata, mis_q};

  assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr = {pc_q[XLEN-1:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mis_d     = mis_q;
    tgt_d     = tgt_q;
    tgt_mis_d = tgt_mis_q;
    buf_d     = buf_q;
    id_load_s = 1'b0;
    id_d_s    = fetched_s;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) begin
          pc_d  = redir_pc_s;
          mis_d = redir_mis_s;
        end else begin
          pc_d  = pc_q;
        end
      end
      FETCH: begin
        if (redirect) begin
          if (imem_ready) begin
            pc_d    = redir_pc_s;
            mis_d   = redir_mis_s;
            state_d = FETCH;
          end else begin
            tgt_d     = redir_pc_s;
            tgt_mis_d = redir_mis_s;
            state_d   = DRAIN;
          end
        end else if (imem_ready) begin
          pc_d  = pc_next(pc_q);
          mis_d = 1'b0;
          if (stall) begin
            buf_d   = fetched_s;
            state_d = HOLD;
          end else begin
            id_load_s = 1'b1;
            state_d   = FETCH;
          end
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d       = redir_pc_s;
          mis_d      = redir_mis_s;
          buf_d.valid = 1'b0;
          buf_d.inst  = NOP;
          state_d    = FETCH;
        end else if (!stall) begin
          id_load_s   = 1'b1;
          id_d_s      = buf_q;
          buf_d.valid = 1'b0;
          buf_d.inst  = NOP;
          state_d     = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        // A newer redirect replaces the pending target; the in-flight word is always dropped.
        if (redirect) begin
          if (imem_ready) begin
            pc_d    = redir_pc_s;
            mis_d   = redir_mis_s;
            state_d = FETCH;
          end else begin
            tgt_d     = redir_pc_s;
            tgt_mis_d = redir_mis_s;
            state_d   = DRAIN;
          end
        end else if (imem_ready) begin
          pc_d    = tgt_q;
          mis_d   = tgt_mis_q;
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      mis_q     <= 1'b0;
      tgt_q     <= RESET_PC;
      tgt_mis_q <= 1'b0;
      buf_q     <= {1'b0, 32'h0000_0000, 32'h0000_0004, NOP, 1'b0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mis_q     <= mis_d;
      tgt_q     <= tgt_d;
      tgt_mis_q <= tgt_mis_d;
      buf_q     <= buf_d;
    end
  end

  if_id_reg u_if_id (
    .clk    (clk),
    .reset  (reset),
    .load_i (id_load_s),
    .stall_i(stall),
    .flush_i(redirect),
    .d_i    (id_d_s),
    .q_o    (id_q_s)
  );

  assign id_valid      = id_q_s.valid;
  assign id_pc         = id_q_s.pc;
  assign id_pc4        = id_q_s.pc4;
  assign id_inst       = id_q_s.inst;
  assign id_misaligned = id_q_s.misaligned;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns addr + 0x00500093 so each word identifies its address.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_misaligned;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 32'h0050_0093;

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_pc4       (id_pc4),
    .id_inst      (id_inst),
    .id_misaligned(id_misaligned)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input string tag, input logic req, input logic [31:0] addr);
    check_eq({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    check_eq({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] pc4, input logic [31:0] inst, input logic mis);
    check_eq({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
    check_eq({tag, ".pc"}, id_pc, pc);
    check_eq({tag, ".pc4"}, id_pc4, pc4);
    check_eq({tag, ".inst"}, id_inst, inst);
    check_eq({tag, ".mis"}, {31'd0, id_misaligned}, {31'd0, mis});
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk_mem("rst", 1'b0, 32'h0);
    chk_id("rst", 1'b0, 32'h0, 32'h4, 32'h0000_0013, 1'b0);

    reset = 1'b0;
    step();
    chk_mem("first_req", 1'b1, 32'h0);
    check_eq("first_req.valid", {31'd0, id_valid}, 32'd0);
    step();
    chk_id("w0", 1'b1, 32'h0, 32'h4, 32'h0050_0093, 1'b0);
    chk_mem("w0", 1'b1, 32'h4);

    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_mem("wait", 1'b1, 32'h4);
      check_eq("wait.valid", {31'd0, id_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    step();
    chk_id("w4", 1'b1, 32'h4, 32'h8, 32'h0050_0097, 1'b0);
    chk_mem("w4", 1'b1, 32'h8);

    stall = 1'b1;
    step();
    chk_mem("hold1", 1'b0, 32'hC);
    chk_id("hold1", 1'b1, 32'h4, 32'h8, 32'h0050_0097, 1'b0);
    step();
    chk_mem("hold2", 1'b0, 32'hC);
    check_eq("hold2.pc", id_pc, 32'h4);
    stall = 1'b0;
    step();
    chk_id("release", 1'b1, 32'h8, 32'hC, 32'h0050_009B, 1'b0);
    chk_mem("release", 1'b1, 32'hC);
    step();
    chk_id("wC", 1'b1, 32'hC, 32'h10, 32'h0050_009F, 1'b0);
    chk_mem("wC", 1'b1, 32'h10);

    imem_ready = 1'b0;
    step();
    check_eq("gap.valid", {31'd0, id_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    chk_mem("drain1", 1'b1, 32'h10);
    chk_id("bubble", 1'b0, 32'hC, 32'h10, 32'h0000_0013, 1'b0);
    redirect = 1'b0;
    step();
    chk_mem("drain2", 1'b1, 32'h10);
    imem_ready = 1'b1;
    step();
    chk_mem("drain_done", 1'b1, 32'h100);
    check_eq("drain_done.valid", {31'd0, id_valid}, 32'd0);
    check_eq("drain_done.inst", id_inst, 32'h0000_0013);
    step();
    chk_id("t100", 1'b1, 32'h100, 32'h104, 32'h0050_0193, 1'b0);

    redirect = 1'b1; redirect_pc = 32'h102; stall = 1'b1;
    step();
    chk_id("redir_stall", 1'b0, 32'h100, 32'h104, 32'h0000_0013, 1'b0);
    chk_mem("redir_stall", 1'b1, 32'h100);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk_id("mis", 1'b1, 32'h100, 32'h104, 32'h0050_0193, 1'b1);
    step();
    chk_id("mis_clr", 1'b1, 32'h104, 32'h108, 32'h0050_0197, 1'b0);

    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk_mem("wrap_req", 1'b1, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step();
    chk_id("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0050_008F, 1'b0);
    chk_mem("wrap", 1'b1, 32'h0);
    step();
    chk_id("after_wrap", 1'b1, 32'h0, 32'h4, 32'h0050_0093, 1'b0);

    imem_ready = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    chk_mem("drain_a", 1'b1, 32'h4);
    redirect_pc = 32'h300;
    step();
    chk_mem("drain_b", 1'b1, 32'h4);
    redirect = 1'b0; imem_ready = 1'b1;
    step();
    chk_mem("retarget", 1'b1, 32'h300);
    step();
    chk_id("t300", 1'b1, 32'h300, 32'h304, 32'h0050_0393, 1'b0);

    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
    step();
    chk_mem("drain_c", 1'b1, 32'h304);
    redirect = 1'b0; reset = 1'b1;
    step();
    chk_mem("rst_drain", 1'b0, 32'h0);
    chk_id("rst_drain", 1'b0, 32'h0, 32'h4, 32'h0000_0013, 1'b0);
    reset = 1'b0; imem_ready = 1'b1;
    step();
    chk_mem("refetch", 1'b1, 32'h0);
    step();
    chk_id("refetch", 1'b1, 32'h0, 32'h4, 32'h0050_0093, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
